// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage with a valid/ready handshake and a
// 2-entry skid buffer, so a downstream stall never reaches in_ready
// combinationally. The stage's control and data bundle travels as one DATA_W
// vector.
//
// Ports:
//   CLK        rising-edge clock
//   AsynClr    asynchronous reset, active-high
//   SynClr     synchronous flush; the stage is EMPTY after the next edge
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  main register holds a payload
//   out_ready  downstream accepts this cycle
//   out_data   main register payload, zero when out_valid=0
//   stall_cnt  saturating stall counter (only with PIPE_STALL_CNT_EN)
//
// Optional feature macro: PIPE_STALL_CNT_EN (adds stall_cnt port and counter).
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              AsynClr,
  input  logic              SynClr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Elaboration-time parameter sanity check
  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_skid: DATA_W and CNT_W must be >= 1");
  end

  // Bit 0 is main_v, bit 1 is skid_v; 2'b10 is unreachable
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = state_q[0] & out_ready;

  // Next-state and data steering
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = BUSY;
          main_data_d = in_data;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_data_d = in_data;
        end else if (push) begin
          state_d     = FULL;
          skid_data_d = in_data;
        end else if (pop) begin
          state_d     = EMPTY;
          main_data_d = '0;
        end
      end
      FULL: begin
        // in_ready_q is 0 here, so only a pop can occur
        if (pop) begin
          state_d     = BUSY;
          main_data_d = skid_data_q;
          skid_data_d = '0;
        end
      end
      default: begin
        state_d     = EMPTY;
        main_data_d = '0;
        skid_data_d = '0;
      end
    endcase

    // Flush wins over any simultaneous push or pop
    if (SynClr) begin
      state_d     = EMPTY;
      main_data_d = '0;
      skid_data_d = '0;
    end

    // Registered ready: computed from the state we are about to enter
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK or posedge AsynClr) begin
    if (AsynClr) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  // main_data_q is zeroed on every path into EMPTY, so no extra gating needed
  assign out_data  = main_data_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of edges where a payload is held back by out_ready=0
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q[0] && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge AsynClr) begin
    if (AsynClr) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a vector table for the skid and
// flush corners, a queue reference model for streaming and random traffic,
// and hand-written reset and stall-counter sequences.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned N_RAND = 10000;

  logic              CLK = 1'b0;
  logic              AsynClr;
  logic              SynClr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mq[$];      // reference contents, front = main
  logic [DATA_W-1:0] in_log[$];  // accepted words (random test)
  logic [DATA_W-1:0] out_log[$]; // words observed leaving the DUT

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .AsynClr   (AsynClr),
    .SynClr    (SynClr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    @(negedge CLK);
    #2;
    AsynClr = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge CLK);
    AsynClr   = 1'b0;
    SynClr    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    mq.delete();
  endtask

  // One cycle against the queue model; checks outputs 1 time unit after the edge
  task automatic step(input logic sclr, input logic v, input logic [DATA_W-1:0] d,
                      input logic r, input bit do_chk);
    bit exp_push, exp_pop;
    SynClr    = sclr;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    exp_push  = v && (mq.size() < 2);
    exp_pop   = (mq.size() > 0) && r;
    if (out_valid && out_ready) out_log.push_back(out_data);
    @(posedge CLK);
    if (sclr) begin
      mq.delete();
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (exp_push) begin
        mq.push_back(d);
        in_log.push_back(d);
      end
    end
    #1;
    if (do_chk) begin
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("m_out_data", 64'(out_data), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
      chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
    end
  endtask

  typedef struct {
    logic              sclr;
    logic              v;
    logic [DATA_W-1:0] d;
    logic              r;
    logic              eov;
    logic [DATA_W-1:0] eod;
    logic              eir;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Skid fill/drain, then flush from FULL and from BUSY
    tbl[0]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h22, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 32'h33, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h55, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 32'h00, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 32'h77, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h77, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};

    AsynClr   = 1'b1;
    SynClr    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #12;
    AsynClr = 1'b0;

    // Reset while FULL
    do_reset();
    step(1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'hAAAA0002, 1'b0, 1'b1);
    do_reset();

    // Vector table
    for (int i = 0; i < 14; i++) begin
      SynClr    = tbl[i].sclr;
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      out_ready = tbl[i].r;
      @(posedge CLK);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
      chk($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].eod));
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
    end

    // Streaming with out_ready high: 1-cycle latency, in_ready stays 1
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, DATA_W'(i), 1'b1, 1'b1);
      chk("stream_data", 64'(out_data), 64'(i));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

`ifdef PIPE_STALL_CNT_EN
    // Stall counter saturation and reset
    do_reset();
    step(1'b0, 1'b1, 32'h5A5A, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("stall_cnt", 64'(stall_cnt), 64'((k > 15) ? 15 : k));
    end
    do_reset();
`endif

    // Random traffic: output sequence must equal accepted input sequence
    do_reset();
    in_log.delete();
    out_log.delete();
    begin
      int cyc = 0;
      while (in_log.size() < N_RAND && cyc < 60000) begin
        step(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        cyc++;
      end
      chk("rand_push_budget", 64'(in_log.size() >= N_RAND), 64'd1);
      cyc = 0;
      while (mq.size() > 0 && cyc < 10) begin
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cyc++;
      end
      // Let the final pop be recorded
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    end
    chk("rand_count", 64'(out_log.size()), 64'(in_log.size()));
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++) begin
      chk($sformatf("rand_order%0d", i), 64'(out_log[i]), 64'(in_log[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
